instr_fetch: RTL and testbench

Instruction fetch stage directly downstream of the program counter. Takes the current PC and the kernel/program space select, issues word reads to the synchronous instruction memory, and buffers returned instructions in a 2-entry queue for the decoder. Drives `pc_hold` back into the PC's `halt` input so the PC only advances when a fetch slot is free. Flushes all in-flight and buffered work when a jump resolves.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 46 ++++
 rtl/instr_fetch.sv | 111 +++++++++++
 tb/tb_instr_fetch.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int          FETCH_DATA_W    = 32;
  localparam int          FETCH_QDEPTH    = 2;
  localparam logic [31:0] FETCH_PROG_BASE = 32'h0000_0400;

  typedef struct packed {
    logic [31:0]             pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched instructions; clear overrides push and pop.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic         i_pop,
  input  fetch_entry_t i_entry,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [FETCH_QDEPTH];
  logic         r_rd;
  logic         r_wr;
  logic [1:0]   r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_clear) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_entry;
        r_wr        <= ~r_wr;
      end
      if (i_pop) begin
        r_rd <= ~r_rd;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issue/inflight/squash control, address generation, 2-deep queue.
// Optional INSTR_FETCH_PERF_EN adds fetch_count and hold_count outputs.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = FETCH_DATA_W,
  parameter logic [31:0] PROG_BASE = FETCH_PROG_BASE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc_at,
  input  logic              prog_or_kernel,
  input  logic              halt,
  input  logic              flush,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_re,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              dec_ready,
  output logic              pc_hold
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       hold_count
`endif
);

  logic         r_inflight;
  logic         r_squash;
  logic [31:0]  r_req_pc;
  logic [31:0]  w_base;
  logic [1:0]   w_occ;
  logic [2:0]   w_level;
  logic         w_pop;
  logic         w_push;
  logic         w_issue;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;

  assign w_base    = prog_or_kernel ? PROG_BASE : 32'd0;
  assign imem_addr = ADDR_W'(pc_at + w_base);

  assign w_pop   = instr_valid & dec_ready;
  assign w_level = {1'b0, w_occ} + {2'b0, r_inflight}
                 - {2'b0, w_pop};
  assign w_issue = !reset & !halt & !flush
                 & (w_level < 3'(FETCH_QDEPTH));

  assign imem_re = w_issue;
  // PC stays free on flush so it can load the jump target
  assign pc_hold = !reset & !w_issue & !flush;

  assign w_push             = r_inflight & !r_squash;
  assign w_push_entry.pc    = r_req_pc;
  assign w_push_entry.instr = imem_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_squash   <= 1'b0;
      r_req_pc   <= 32'd0;
    end else begin
      r_inflight <= w_issue;
      r_squash   <= flush & r_inflight;
      if (w_issue) begin
        r_req_pc <= pc_at;
      end
    end
  end

  fetch_queue u_queue (
    .clock   (clock),
    .reset   (reset),
    .i_clear (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_entry (w_push_entry),
    .o_head  (w_head),
    .o_count (w_occ)
  );

  assign instr_valid = (w_occ != 2'd0);
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_hold_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_count <= 32'd0;
      r_hold_count  <= 32'd0;
    end else begin
      if (w_issue) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (pc_hold) begin
        r_hold_count <= r_hold_count + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_count;
  assign hold_count  = r_hold_count;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector table plus a streaming scoreboard for instr_fetch.
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_at;
  logic        prog_or_kernel;
  logic        halt;
  logic        flush;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        dec_ready;
  logic        pc_hold;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] hold_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  instr_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .pc_at          (pc_at),
    .prog_or_kernel (prog_or_kernel),
    .halt           (halt),
    .flush          (flush),
    .imem_addr      (imem_addr),
    .imem_re        (imem_re),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .dec_ready      (dec_ready),
    .pc_hold        (pc_hold)
`ifdef INSTR_FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .hold_count     (hold_count)
`endif
  );

  // Synchronous memory: word at address a reads as ~a; idle cycles return junk
  always @(posedge clock) begin
    imem_rdata <= imem_re ? ~imem_addr : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        pr;
    logic        hl;
    logic        fl;
    logic        dr;
    logic [31:0] e_addr;
    logic        e_re;
    logic        e_hold;
    logic        e_val;
    logic        chk;
    logic [31:0] e_ipc;
    logic [31:0] e_ins;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic rst, input logic [31:0] pc,
    input logic pr, input logic hl,
    input logic fl, input logic dr,
    input logic [31:0] ea, input logic er,
    input logic eh, input logic ev,
    input logic ck, input logic [31:0] ep,
    input logic [31:0] ei);
    vec_t v;
    v.rst = rst; v.pc = pc; v.pr = pr;
    v.hl = hl; v.fl = fl; v.dr = dr;
    v.e_addr = ea; v.e_re = er; v.e_hold = eh;
    v.e_val = ev; v.chk = ck; v.e_ipc = ep;
    v.e_ins = ei;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  int unsigned exp_pc;
  int          pops;
  logic        hold_s;

  initial begin
    reset = 1'b1; pc_at = '0; prog_or_kernel = 1'b0;
    halt = 1'b0; flush = 1'b0; dec_ready = 1'b1;

    // c0: reset held; streaming in kernel space
    add(1, 0, 0,0,0,1, 0,     0,0,0, 1, 0, 0);
    add(0, 0, 0,0,0,1, 0,     1,0,0, 0, 0, 0);
    add(0, 1, 0,0,0,1, 1,     1,0,0, 0, 0, 0);
    add(0, 2, 0,0,0,1, 2,     1,0,1, 1, 0, ~32'd0);
    add(0, 3, 0,0,0,1, 3,     1,0,1, 1, 1, ~32'd1);
    add(0, 4, 0,0,0,1, 4,     1,0,1, 1, 2, ~32'd2);
    // c6..c9: decoder stalls, queue fills to 2
    add(0, 5, 0,0,0,0, 5,     0,1,1, 1, 3, ~32'd3);
    add(0, 5, 0,0,0,0, 5,     0,1,1, 1, 3, ~32'd3);
    add(0, 5, 0,0,0,0, 5,     0,1,1, 1, 3, ~32'd3);
    add(0, 5, 0,0,0,0, 5,     0,1,1, 1, 3, ~32'd3);
    add(0, 5, 0,0,0,1, 5,     1,0,1, 1, 3, ~32'd3);
    add(0, 6, 0,0,0,1, 6,     1,0,1, 1, 4, ~32'd4);
    add(0, 7, 0,0,0,1, 7,     1,0,1, 1, 5, ~32'd5);
    // c13: flush with occ=1 and a read in flight
    add(0, 7, 0,0,1,1, 7,     0,0,1, 1, 6, ~32'd6);
    add(0, 32'h20, 0,0,0,1, 32'h20, 1,0,0, 0, 0, 0);
    add(0, 32'h21, 0,0,0,1, 32'h21, 1,0,0, 0, 0, 0);
    add(0, 32'h22, 0,0,0,1, 32'h22, 1,0,1, 1, 32'h20, ~32'h20);
    // c17: flush into program space
    add(0, 5, 1,0,1,1, 32'h405, 0,0,1, 1, 32'h21, ~32'h21);
    add(0, 5, 1,0,0,1, 32'h405, 1,0,0, 0, 0, 0);
    add(0, 6, 1,0,0,1, 32'h406, 1,0,0, 0, 0, 0);
    add(0, 7, 1,0,0,1, 32'h407, 1,0,1, 1, 5, ~32'h405);
    add(0, 8, 1,0,0,0, 32'h408, 0,1,1, 1, 6, ~32'h406);
    // c22: halt drains both queued entries
    add(0, 8, 1,1,0,1, 32'h408, 0,1,1, 1, 6, ~32'h406);
    add(0, 8, 1,1,0,1, 32'h408, 0,1,1, 1, 7, ~32'h407);
    add(0, 8, 1,1,0,1, 32'h408, 0,1,0, 0, 0, 0);
    add(0, 8, 1,0,0,1, 32'h408, 1,0,0, 0, 0, 0);
    // c26: reset the cycle after an issue
    add(1, 9, 1,0,0,1, 32'h409, 0,0,0, 0, 0, 0);
    add(0, 0, 0,0,0,1, 0,     1,0,0, 1, 0, 0);
    add(0, 1, 0,0,0,1, 1,     1,0,0, 1, 0, 0);
    add(0, 2, 0,0,0,1, 2,     1,0,1, 1, 0, ~32'd0);

    repeat (2) @(posedge clock);
    #1;
    foreach (vq[i]) begin
      reset          = vq[i].rst;
      pc_at          = vq[i].pc;
      prog_or_kernel = vq[i].pr;
      halt           = vq[i].hl;
      flush          = vq[i].fl;
      dec_ready      = vq[i].dr;
      @(negedge clock);
      chk($sformatf("v%0d imem_addr", i), imem_addr, vq[i].e_addr);
      chk($sformatf("v%0d imem_re", i), 32'(imem_re), 32'(vq[i].e_re));
      chk($sformatf("v%0d pc_hold", i), 32'(pc_hold), 32'(vq[i].e_hold));
      chk($sformatf("v%0d instr_valid", i), 32'(instr_valid),
          32'(vq[i].e_val));
      if (vq[i].chk) begin
        chk($sformatf("v%0d instr_pc", i), instr_pc, vq[i].e_ipc);
        chk($sformatf("v%0d instr", i), instr, vq[i].e_ins);
      end
      @(posedge clock);
      #1;
    end

    // Streaming scoreboard: PC advances whenever pc_hold is low
    reset = 1'b1; halt = 1'b0; flush = 1'b0;
    prog_or_kernel = 1'b0; dec_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    pc_at = 32'h100;
    exp_pc = 32'h100;
    pops = 0;
    for (int k = 0; k < 60; k++) begin
      dec_ready = (k % 3) != 2;
      @(negedge clock);
      hold_s = pc_hold;
      if (instr_valid && dec_ready) begin
        chk($sformatf("s%0d instr_pc", k), instr_pc, exp_pc);
        chk($sformatf("s%0d instr", k), instr, ~exp_pc);
        exp_pc++;
        pops++;
      end
      @(posedge clock);
      #1;
      if (!hold_s) pc_at = pc_at + 32'd1;
    end
    n_cmp++;
    if (pops < 30) begin
      n_bad++;
      $display("FAIL stream_pops: got %0d want >= 30", pops);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
